trigger_sequencer: RTL and testbench
====================================

# trigger_sequencer

Programmable burst scheduler for the DAC/ADC trigger datapath. It replaces a free-running fixed-period pulse generator with a sequenced one. Software loads period, pulse width, start delay and pulse count through a valid/ready config port. A start request then produces a delayed burst of N periodic trigger pulses, or a continuous train, and signals completion. It sits between the control-register block and every consumer of `trigger_out`.

## Interface
- `CNT_W`, 32, width of period/width/delay fields and internal phase counter
- `IDX_W`, 16, width of pulse count and pulse index
- `DEF_PERIOD`, 4096, period loaded at reset (cycles)
- `DEF_WIDTH`, 1, high-time loaded at reset (cycles)
- `DEF_COUNT`, 1, pulse count loaded at reset
- `aclk` in 1: single clock; all logic on rising edge
- `areset` in 1: reset, asynchronous, active-high
- `cfg_valid` in 1: config beat valid
- `cfg_ready` out 1: high only in IDLE
- `cfg_period` in CNT_W: pulse period in cycles
- `cfg_width` in CNT_W: trigger high-time per period in cycles
- `cfg_delay` in CNT_W: cycles from start acceptance to first pulse
- `cfg_count` in IDX_W: pulses per burst; 0 = continuous until stop
- `start` in 1: level-sampled start request
- `stop` in 1: level-sampled abort
- `busy` out 1: high in DELAY or RUN
- `done` out 1: one-cycle pulse on natural burst completion
- `trigger_out` out 1: registered trigger
- `pulse_idx` out IDX_W: 0-based index of the current pulse

## Operation
- Config is accepted on any edge with `cfg_valid && cfg_ready`. All four fields are latched together.
- Latched period of 0 is treated as 1.
- States: IDLE, DELAY, RUN.
- IDLE → DELAY on `start` when delay > 0. IDLE → RUN on `start` when delay = 0.
- DELAY counts delay cycles, then → RUN.
- RUN: the phase counter runs 0..period-1 and wraps. `trigger_out` is high while phase < width.
  - Width 0: trigger never rises; the burst still runs its full duration.
  - Width ≥ period: trigger stays high for the whole burst.
- `pulse_idx` increments on each phase wrap. In continuous mode it wraps modulo 2^IDX_W.
- After `cfg_count` full periods: RUN → IDLE, `done` = 1 for that single cycle, `trigger_out` = 0.
- `stop` in DELAY or RUN: → IDLE on the next edge, `trigger_out` = 0, no `done`.
- Ignored inputs:
  - `start` while busy is ignored.
  - `stop` in IDLE is a no-op.
  - `start && stop` in IDLE: stop wins, start is ignored.
- Config accepted on the same edge as `start` updates the registers, but the launched burst uses the previous values. The new config applies to the next burst.
- Reset values:
  - state IDLE
  - `cfg_ready` = 1
  - `busy`, `done`, `trigger_out` = 0
  - `pulse_idx` = 0
  - config registers = DEF_* with delay 0
- Reset asserted mid-burst aborts immediately and asynchronously to the values above.

## Timing
- Start accepted at edge k: `busy` high after edge k.
- `trigger_out` first rises at edge k+1+delay.
- Each high time lasts width cycles; pulse rising edges are period cycles apart.
- The last period ends at edge k+1+delay+count·period. On that edge `busy` falls and `done` rises; `done` falls one edge later.
- Back-to-back burst: `start` held high relaunches on the edge after `done`, giving a one-cycle IDLE gap.
- `pulse_idx` resets to 0 on start acceptance and holds its last value in IDLE.
- `cfg_ready` is combinational from state. There is no other combinational input-to-output path.

## Configuration
- `TRIG_SEQ_EXT_START_EN` defined:
  - Adds input `ext_start` (1 bit, asynchronous to `aclk`).
  - `ext_start` passes through a 2-FF synchronizer and rising-edge detector. The detected edge is ORed with `start`.
  - Fixed added latency: 3 cycles from the `ext_start` rise to start acceptance.
  - Same ignore/priority rules as `start`.
- Undefined: the `ext_start` port and synchronizer are absent, and start comes only from `start`.

## Test plan
- Reset defaults, then `start` with no config load → single pulse, high 1 cycle, rising 1 cycle after start acceptance. `done` at start+4097; `cfg_ready` = 1 throughout reset.
- Config period=10, width=3, delay=5, count=4 → 4 pulses, 3 cycles high each, first rise at k+6. Rises at k+6/16/26/36, `done` at k+46, `pulse_idx` 0..3.
- Config count=0, period=4, width=2, `stop` after 11 RUN cycles → continuous pulses, then `trigger_out` = 0 and `busy` = 0 on the next edge, no `done`.
- Edge cases:
  - width=0 → `trigger_out` never rises, `done` still fires.
  - width=8, period=4 → `trigger_out` constant high for the burst.
  - period=0 → behaves as period 1.
- Same-edge and mid-burst events:
  - `start` + `stop` together in IDLE → stays IDLE.
  - `start` + config together → burst uses the old config, the next burst uses the new one.
  - `areset` pulsed mid-RUN → all outputs return to reset values immediately.
- With `TRIG_SEQ_EXT_START_EN`: `ext_start` rising edge from IDLE → start accepted exactly 3 cycles later. `ext_start` held high → exactly one burst.

Source files
------------

// File: rtl/trigger_sequencer_if.sv
// trigger_sequencer_if: config, control and status bundle of the trigger
// sequencer. The master side is the control-register block; the slave side
// is the sequencer itself.
interface trigger_sequencer_if #(
  parameter int CNT_W = 32,
  parameter int IDX_W = 16
);
  logic             cfg_valid;
  logic             cfg_ready;
  logic [CNT_W-1:0] cfg_period;
  logic [CNT_W-1:0] cfg_width;
  logic [CNT_W-1:0] cfg_delay;
  logic [IDX_W-1:0] cfg_count;
  logic             start;
  logic             stop;
  logic             busy;
  logic             done;
  logic             trigger_out;
  logic [IDX_W-1:0] pulse_idx;

  modport master (
    output cfg_valid, cfg_period, cfg_width, cfg_delay, cfg_count, start, stop,
    input  cfg_ready, busy, done, trigger_out, pulse_idx
  );

  modport slave (
    input  cfg_valid, cfg_period, cfg_width, cfg_delay, cfg_count, start, stop,
    output cfg_ready, busy, done, trigger_out, pulse_idx
  );
endinterface

// File: rtl/trigger_sequencer.sv
// trigger_sequencer: programmable burst scheduler for the trigger datapath.
// A start request launches an optional delay followed by a burst of periodic
// pulses (or a continuous train when the count is zero).
// Optional feature: define TRIG_SEQ_EXT_START_EN to add the asynchronous
// ext_start input (2-FF synchronizer + rising-edge detect, ORed with start).
module trigger_sequencer #(
  parameter int          CNT_W      = 32,
  parameter int          IDX_W      = 16,
  parameter int unsigned DEF_PERIOD = 4096,
  parameter int unsigned DEF_WIDTH  = 1,
  parameter int unsigned DEF_COUNT  = 1
) (
  input  logic aclk,
  input  logic areset,
`ifdef TRIG_SEQ_EXT_START_EN
  input  logic ext_start,
`endif
  trigger_sequencer_if.slave bus
);

  typedef enum logic [1:0] {IDLE, DELAY, RUN} state_t;

  localparam logic [CNT_W-1:0] CNT_ZERO = '0;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [IDX_W-1:0] IDX_ZERO = '0;
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cfgPeriod_q, cfgPeriod_d;
  logic [CNT_W-1:0] cfgWidth_q, cfgWidth_d;
  logic [CNT_W-1:0] cfgDelay_q, cfgDelay_d;
  logic [IDX_W-1:0] cfgCount_q, cfgCount_d;
  logic [CNT_W-1:0] runPeriod_q, runPeriod_d;
  logic [CNT_W-1:0] runWidth_q, runWidth_d;
  logic [IDX_W-1:0] runCount_q, runCount_d;
  logic [CNT_W-1:0] dly_q, dly_d;
  logic [CNT_W-1:0] cyc_q, cyc_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             trig_q, trig_d;
  logic             done_q, done_d;
  logic             startReq;

`ifdef TRIG_SEQ_EXT_START_EN
  logic sync1_q, sync2_q, sync3_q;

  // Bring ext_start into the aclk domain and keep one extra stage for edge detection
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      sync3_q <= 1'b0;
    end else begin
      sync1_q <= ext_start;
      sync2_q <= sync1_q;
      sync3_q <= sync2_q;
    end
  end

  assign startReq = bus.start | (sync2_q & ~sync3_q);
`else
  assign startReq = bus.start;
`endif

  // Registers: state, programmed config, burst snapshot, counters and outputs
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_q     <= IDLE;
      cfgPeriod_q <= CNT_W'(DEF_PERIOD);
      cfgWidth_q  <= CNT_W'(DEF_WIDTH);
      cfgDelay_q  <= CNT_ZERO;
      cfgCount_q  <= IDX_W'(DEF_COUNT);
      runPeriod_q <= CNT_W'(DEF_PERIOD);
      runWidth_q  <= CNT_W'(DEF_WIDTH);
      runCount_q  <= IDX_W'(DEF_COUNT);
      dly_q       <= CNT_ZERO;
      cyc_q       <= CNT_ZERO;
      idx_q       <= IDX_ZERO;
      trig_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cfgPeriod_q <= cfgPeriod_d;
      cfgWidth_q  <= cfgWidth_d;
      cfgDelay_q  <= cfgDelay_d;
      cfgCount_q  <= cfgCount_d;
      runPeriod_q <= runPeriod_d;
      runWidth_q  <= runWidth_d;
      runCount_q  <= runCount_d;
      dly_q       <= dly_d;
      cyc_q       <= cyc_d;
      idx_q       <= idx_d;
      trig_q      <= trig_d;
      done_q      <= done_d;
    end
  end

  // Next state: launch from the old config snapshot, count delay, then emit
  // periods; cyc_q is the number of cycles already emitted in this period
  always_comb begin
    state_d     = state_q;
    cfgPeriod_d = cfgPeriod_q;
    cfgWidth_d  = cfgWidth_q;
    cfgDelay_d  = cfgDelay_q;
    cfgCount_d  = cfgCount_q;
    runPeriod_d = runPeriod_q;
    runWidth_d  = runWidth_q;
    runCount_d  = runCount_q;
    dly_d       = dly_q;
    cyc_d       = cyc_q;
    idx_d       = idx_q;
    trig_d      = 1'b0;
    done_d      = 1'b0;

    if (bus.cfg_valid && (state_q == IDLE)) begin
      cfgPeriod_d = bus.cfg_period;
      cfgWidth_d  = bus.cfg_width;
      cfgDelay_d  = bus.cfg_delay;
      cfgCount_d  = bus.cfg_count;
    end

    unique case (state_q)
      IDLE: begin
        if (startReq && !bus.stop) begin
          runPeriod_d = (cfgPeriod_q == CNT_ZERO) ? CNT_ONE : cfgPeriod_q;
          runWidth_d  = cfgWidth_q;
          runCount_d  = cfgCount_q;
          idx_d       = IDX_ZERO;
          cyc_d       = CNT_ZERO;
          if (cfgDelay_q == CNT_ZERO) begin
            state_d = RUN;
          end else begin
            state_d = DELAY;
            dly_d   = cfgDelay_q - CNT_ONE;
          end
        end
      end
      DELAY: begin
        if (bus.stop) begin
          state_d = IDLE;
        end else if (dly_q == CNT_ZERO) begin
          state_d = RUN;
          cyc_d   = CNT_ZERO;
        end else begin
          dly_d = dly_q - CNT_ONE;
        end
      end
      RUN: begin
        if (bus.stop) begin
          state_d = IDLE;
        end else if (cyc_q == runPeriod_q) begin
          if ((runCount_q != IDX_ZERO) && (idx_q == runCount_q - IDX_ONE)) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            idx_d  = idx_q + IDX_ONE;
            trig_d = (runWidth_q != CNT_ZERO);
            cyc_d  = CNT_ONE;
          end
        end else begin
          trig_d = (cyc_q < runWidth_q);
          cyc_d  = cyc_q + CNT_ONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.cfg_ready   = (state_q == IDLE);
  assign bus.busy        = (state_q != IDLE);
  assign bus.done        = done_q;
  assign bus.trigger_out = trig_q;
  assign bus.pulse_idx   = idx_q;

endmodule

// File: tb/tb_trigger_sequencer.sv
// tb_trigger_sequencer: directed and randomized bench for trigger_sequencer.
// A timeline model predicts every output from the start cycle of the current
// burst; directed scenarios also pin the model against hand-computed offsets.
// Define TRIG_SEQ_EXT_START_EN to exercise the ext_start path as well.
`timescale 1ns/1ps
module tb_trigger_sequencer;
  localparam int CNT_W = 32;
  localparam int IDX_W = 16;

  logic aclk   = 1'b0;
  logic areset = 1'b0;
`ifdef TRIG_SEQ_EXT_START_EN
  logic extStart = 1'b0;
  bit   extHist [3];
`endif

  trigger_sequencer_if #(.CNT_W(CNT_W), .IDX_W(IDX_W)) bus ();

  trigger_sequencer #(
    .CNT_W(CNT_W), .IDX_W(IDX_W),
    .DEF_PERIOD(4096), .DEF_WIDTH(1), .DEF_COUNT(1)
  ) dut (
    .aclk(aclk),
    .areset(areset),
`ifdef TRIG_SEQ_EXT_START_EN
    .ext_start(extStart),
`endif
    .bus(bus)
  );

  always #5 aclk = ~aclk;

  int unsigned total = 0;
  int unsigned bad   = 0;
  bit          checkEn = 1'b0;

  longint      tick = 0;
  logic [31:0] mCfgP = 32'd4096, mCfgW = 32'd1, mCfgD = 32'd0;
  logic [15:0] mCfgN = 16'd1;
  bit          mActive = 1'b0;
  longint      mK = 0, mP = 1, mW = 0, mD = 0, mN = 0;
  logic [15:0] mIdx = 16'd0;
  bit          expBusy = 1'b0, expDone = 1'b0, expTrig = 1'b0, prevTrig = 1'b0;
  logic [15:0] expIdx = 16'd0;
  bit          sReq;
  longint      endT, r;

  longint      riseQ [$];
  longint      startQ [$];
  longint      doneOff = -1;
  longint      highCnt = 0;
  longint      maxIdx = 0;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Timeline model: outputs follow from the burst start cycle by plain arithmetic
  always @(posedge aclk or posedge areset) begin
    if (areset) begin
      mCfgP = 32'd4096; mCfgW = 32'd1; mCfgD = 32'd0; mCfgN = 16'd1;
      mActive = 1'b0; mIdx = 16'd0;
      expBusy = 1'b0; expDone = 1'b0; expTrig = 1'b0; expIdx = 16'd0; prevTrig = 1'b0;
`ifdef TRIG_SEQ_EXT_START_EN
      extHist = '{1'b0, 1'b0, 1'b0};
`endif
    end else begin
      tick++;
      sReq = bus.start;
`ifdef TRIG_SEQ_EXT_START_EN
      sReq = sReq | (extHist[1] & ~extHist[2]);
      extHist[2] = extHist[1];
      extHist[1] = extHist[0];
      extHist[0] = extStart;
`endif
      expDone = 1'b0;
      expTrig = 1'b0;
      if (mActive) begin
        endT = mK + 1 + mD + mN * mP;
        if (bus.stop) begin
          mActive = 1'b0;
        end else if ((mN != 0) && (tick == endT)) begin
          mActive = 1'b0;
          expDone = 1'b1;
          doneOff = tick - mK;
        end else begin
          r = tick - (mK + 1 + mD);
          if (r >= 0) begin
            expTrig = ((r % mP) < mW);
            mIdx    = 16'(r / mP);
          end
        end
      end else begin
        if (sReq && !bus.stop) begin
          mActive = 1'b1;
          mK = tick;
          mP = (mCfgP == 0) ? 1 : longint'(mCfgP);
          mW = longint'(mCfgW);
          mD = longint'(mCfgD);
          mN = longint'(mCfgN);
          mIdx = 16'd0;
          startQ.push_back(tick);
        end
        if (bus.cfg_valid) begin
          mCfgP = bus.cfg_period;
          mCfgW = bus.cfg_width;
          mCfgD = bus.cfg_delay;
          mCfgN = bus.cfg_count;
        end
      end
      expBusy = mActive;
      expIdx  = mIdx;
      if (expTrig && !prevTrig) riseQ.push_back(tick - mK);
      if (expTrig) highCnt++;
      if (mActive && (longint'(mIdx) > maxIdx)) maxIdx = longint'(mIdx);
      prevTrig = expTrig;
    end
  end

  // Compare every DUT output against the model in the middle of each cycle
  always @(negedge aclk) begin
    if (checkEn) begin
      checkOutput("busy", 64'(bus.busy), 64'(expBusy));
      checkOutput("cfg_ready", 64'(bus.cfg_ready), 64'(!expBusy));
      checkOutput("done", 64'(bus.done), 64'(expDone));
      checkOutput("trigger_out", 64'(bus.trigger_out), 64'(expTrig));
      checkOutput("pulse_idx", 64'(bus.pulse_idx), 64'(expIdx));
    end
  end

  task automatic stepCycles(input int n);
    repeat (n) begin
      @(posedge aclk);
      #2;
    end
  endtask

  task automatic applyStimulus(input bit s, input bit st, input bit cv,
                               input logic [31:0] p, input logic [31:0] w,
                               input logic [31:0] d, input logic [15:0] n);
    bus.start      = s;
    bus.stop       = st;
    bus.cfg_valid  = cv;
    bus.cfg_period = p;
    bus.cfg_width  = w;
    bus.cfg_delay  = d;
    bus.cfg_count  = n;
    stepCycles(1);
    bus.start     = 1'b0;
    bus.stop      = 1'b0;
    bus.cfg_valid = 1'b0;
  endtask

  task automatic clearLog();
    riseQ.delete();
    startQ.delete();
    doneOff = -1;
    highCnt = 0;
    maxIdx  = 0;
  endtask

  task automatic waitIdle(input int budget);
    int c;
    c = 0;
    while ((bus.busy || expBusy) && (c < budget)) begin
      stepCycles(1);
      c++;
    end
    if (c >= budget) begin
      total++;
      bad++;
      $display("[TB] FAIL wait_idle: still busy after %0d cycles", budget);
    end
    stepCycles(1);
  endtask

  initial begin
    bus.cfg_valid = 1'b0; bus.cfg_period = '0; bus.cfg_width = '0;
    bus.cfg_delay = '0; bus.cfg_count = '0; bus.start = 1'b0; bus.stop = 1'b0;
    #1 areset = 1'b1;
    checkEn = 1'b1;
    repeat (3) @(posedge aclk);
    #2 areset = 1'b0;
    stepCycles(2);

    $display("[TB] default single pulse");
    clearLog();
    applyStimulus(1, 0, 0, 0, 0, 0, 0);
    waitIdle(5000);
    checkOutput("dflt_done_off", doneOff, 4097);
    checkOutput("dflt_rises", riseQ.size(), 1);
    checkOutput("dflt_rise0", riseQ[0], 1);
    checkOutput("dflt_high", highCnt, 1);

    $display("[TB] period 10 width 3 delay 5 count 4");
    applyStimulus(0, 0, 1, 10, 3, 5, 4);
    clearLog();
    applyStimulus(1, 0, 0, 0, 0, 0, 0);
    waitIdle(200);
    checkOutput("p10_rises", riseQ.size(), 4);
    checkOutput("p10_rise0", riseQ[0], 6);
    checkOutput("p10_rise1", riseQ[1], 16);
    checkOutput("p10_rise2", riseQ[2], 26);
    checkOutput("p10_rise3", riseQ[3], 36);
    checkOutput("p10_done_off", doneOff, 46);
    checkOutput("p10_high", highCnt, 12);
    checkOutput("p10_max_idx", maxIdx, 3);

    $display("[TB] continuous with stop");
    applyStimulus(0, 0, 1, 4, 2, 0, 0);
    clearLog();
    applyStimulus(1, 0, 0, 0, 0, 0, 0);
    stepCycles(11);
    applyStimulus(0, 1, 0, 0, 0, 0, 0);
    checkOutput("cont_busy_after_stop", 64'(bus.busy), 0);
    checkOutput("cont_trig_after_stop", 64'(bus.trigger_out), 0);
    checkOutput("cont_done_after_stop", 64'(bus.done), 0);
    stepCycles(5);
    checkOutput("cont_rises", riseQ.size(), 3);
    checkOutput("cont_rise2", riseQ[2], 9);
    checkOutput("cont_no_done", doneOff, -1);

    $display("[TB] width 0");
    applyStimulus(0, 0, 1, 3, 0, 0, 2);
    clearLog();
    applyStimulus(1, 0, 0, 0, 0, 0, 0);
    waitIdle(100);
    checkOutput("w0_rises", riseQ.size(), 0);
    checkOutput("w0_done_off", doneOff, 7);

    $display("[TB] width above period");
    applyStimulus(0, 0, 1, 4, 8, 2, 2);
    clearLog();
    applyStimulus(1, 0, 0, 0, 0, 0, 0);
    waitIdle(100);
    checkOutput("wide_rises", riseQ.size(), 1);
    checkOutput("wide_rise0", riseQ[0], 3);
    checkOutput("wide_high", highCnt, 8);
    checkOutput("wide_done_off", doneOff, 11);

    $display("[TB] period 0");
    applyStimulus(0, 0, 1, 0, 1, 0, 3);
    clearLog();
    applyStimulus(1, 0, 0, 0, 0, 0, 0);
    waitIdle(100);
    checkOutput("p0_rises", riseQ.size(), 1);
    checkOutput("p0_high", highCnt, 3);
    checkOutput("p0_done_off", doneOff, 4);

    $display("[TB] start and stop together in idle");
    clearLog();
    applyStimulus(1, 1, 0, 0, 0, 0, 0);
    checkOutput("ss_busy", 64'(bus.busy), 0);
    stepCycles(4);
    checkOutput("ss_no_start", startQ.size(), 0);

    $display("[TB] start with config on the same edge");
    applyStimulus(0, 0, 1, 5, 2, 1, 2);
    clearLog();
    applyStimulus(1, 0, 1, 3, 1, 0, 1);
    waitIdle(100);
    checkOutput("old_cfg_done_off", doneOff, 12);
    checkOutput("old_cfg_rises", riseQ.size(), 2);
    checkOutput("old_cfg_rise1", riseQ[1], 7);
    clearLog();
    applyStimulus(1, 0, 0, 0, 0, 0, 0);
    waitIdle(100);
    checkOutput("new_cfg_done_off", doneOff, 4);
    checkOutput("new_cfg_rise0", riseQ[0], 1);

    $display("[TB] back-to-back with start held");
    applyStimulus(0, 0, 1, 2, 1, 0, 1);
    clearLog();
    bus.start = 1'b1;
    stepCycles(10);
    bus.start = 1'b0;
    waitIdle(50);
    checkOutput("b2b_gap", startQ[1] - startQ[0], 4);

    $display("[TB] reset mid-run");
    applyStimulus(0, 0, 1, 2, 1, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 0, 0);
    stepCycles(6);
    areset = 1'b1;
    #1;
    checkOutput("rst_busy", 64'(bus.busy), 0);
    checkOutput("rst_trig", 64'(bus.trigger_out), 0);
    checkOutput("rst_done", 64'(bus.done), 0);
    checkOutput("rst_idx", 64'(bus.pulse_idx), 0);
    checkOutput("rst_ready", 64'(bus.cfg_ready), 1);
    stepCycles(2);
    areset = 1'b0;
    stepCycles(2);

`ifdef TRIG_SEQ_EXT_START_EN
    begin
      longint riseTick;
      $display("[TB] ext_start");
      applyStimulus(0, 0, 1, 2, 1, 0, 1);
      clearLog();
      riseTick = tick;
      extStart = 1'b1;
      stepCycles(20);
      checkOutput("ext_bursts", startQ.size(), 1);
      checkOutput("ext_latency", startQ[0] - riseTick, 3);
      extStart = 1'b0;
      stepCycles(4);
    end
`endif

    $display("[TB] randomized traffic");
    for (int i = 0; i < 3000; i++) begin
      bus.start      = ($urandom_range(0, 9) == 0);
      bus.stop       = ($urandom_range(0, 39) == 0);
      bus.cfg_valid  = ($urandom_range(0, 7) == 0);
      bus.cfg_period = 32'($urandom_range(0, 6));
      bus.cfg_width  = 32'($urandom_range(0, 8));
      bus.cfg_delay  = 32'($urandom_range(0, 4));
      bus.cfg_count  = 16'($urandom_range(0, 4));
      stepCycles(1);
    end
    bus.start = 1'b0;
    bus.cfg_valid = 1'b0;
    bus.stop = 1'b1;
    stepCycles(1);
    bus.stop = 1'b0;
    stepCycles(3);

    checkEn = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
